// File: rtl/arcade_input_pkg.sv
// ---------------------------------------------------------------------------
// arcade_input_pkg
// Shared definitions for the arcade player-input front end:
//   - PS/2 scancodes for both player key banks
//   - joystick / held-key bit indices
//   - coin generator state encoding
//   - helpers: counter width calculation and orientation remap
// No ports (package).
// ---------------------------------------------------------------------------
package arcade_input_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } coin_state_t;

   // Joystick word bit positions (hps_io layout).
   localparam int JOY_RIGHT  = 0;
   localparam int JOY_LEFT   = 1;
   localparam int JOY_DOWN   = 2;
   localparam int JOY_UP     = 3;
   localparam int JOY_FIRE   = 4;
   localparam int JOY_BOMB   = 5;
   localparam int JOY_START1 = 6;
   localparam int JOY_START2 = 7;
   localparam int JOY_COIN   = 8;

   // Held-key register layout; bits 0..5 line up with the joystick bits
   // so the merge is a plain bitwise OR.
   localparam int KEY_START = 6;
   localparam int KEY_COIN  = 7;

   // Player 1 keys matched on the 8-bit code only (extended bit ignored).
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_BOMB1 = 8'h14;

   // Keys matched on {extended, code}.
   localparam logic [8:0] SC_FIRE1  = 9'h029;
   localparam logic [8:0] SC_START1 = 9'h005;
   localparam logic [8:0] SC_COIN1  = 9'h02E;
   localparam logic [8:0] SC_UP2    = 9'h02D;
   localparam logic [8:0] SC_DOWN2  = 9'h02B;
   localparam logic [8:0] SC_LEFT2  = 9'h023;
   localparam logic [8:0] SC_RIGHT2 = 9'h034;
   localparam logic [8:0] SC_FIRE2  = 9'h01C;
   localparam logic [8:0] SC_BOMB2  = 9'h01B;
   localparam logic [8:0] SC_START2 = 9'h006;
   localparam logic [8:0] SC_COIN2  = 9'h036;

   // Width of a down-counter able to hold the larger of two reload values.
   function automatic int cnt_width(input int a, input int b);
      return $clog2(((a > b) ? a : b) + 1);
   endfunction

   // Horizontal-orientation remap of a 6-bit player word; fire/bomb pass.
   function automatic logic [5:0] remap(input logic [5:0] d, input logic rot);
      logic [5:0] r;
      r = d;
      if (rot) begin
         r[JOY_UP]    = d[JOY_LEFT];
         r[JOY_DOWN]  = d[JOY_RIGHT];
         r[JOY_LEFT]  = d[JOY_DOWN];
         r[JOY_RIGHT] = d[JOY_UP];
      end
      return r;
   endfunction

endpackage

// File: rtl/arcade_input_ctrl_coin.sv
// ---------------------------------------------------------------------------
// coin_pulse_gen
// One coin slot: a rising edge on req (seen only in IDLE) produces a coin
// pulse of COIN_PULSE cycles followed by a lockout gap of COIN_PULSE cycles.
// Ports:
//   clk_sys  in   system clock
//   reset_n  in   asynchronous active-low reset
//   req      in   coin request (combinational, already merged)
//   coin     out  registered coin pulse
//   state    out  FSM state, for observation
// ---------------------------------------------------------------------------
module coin_pulse_gen
   import arcade_input_pkg::*;
#(
   parameter logic [15:0] COIN_PULSE = 16'd32768,
   parameter int          CNT_W      = 16
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        req,
   output logic        coin,
   output coin_state_t state
);

   localparam logic [CNT_W-1:0] LOAD = CNT_W'(COIN_PULSE - 16'd1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   coin_state_t      state_next;
   logic [CNT_W-1:0] cnt_q, cnt_next;
   logic             req_q;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt_q <= '0;
         req_q <= 1'b0;
         coin  <= 1'b0;
      end else begin
         state <= state_next;
         cnt_q <= cnt_next;
         // Tracked in every state so an edge during PULSE/GAP, or a request
         // still held when GAP ends, cannot start a pulse later.
         req_q <= req;
         coin  <= (state_next == PULSE);
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt_q;
      case (state)
         IDLE: begin
            if (req && !req_q) begin
               state_next = PULSE;
               cnt_next   = LOAD;
            end
         end
         PULSE: begin
            if (cnt_q == '0) begin
               state_next = GAP;
               cnt_next   = LOAD;
            end else begin
               cnt_next = cnt_q - ONE;
            end
         end
         GAP: begin
            if (cnt_q == '0) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_q - ONE;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

endmodule

// File: rtl/arcade_input_ctrl.sv
// ---------------------------------------------------------------------------
// arcade_input_ctrl
// Player-input front end: PS/2 key decode into held-key state for two
// players, merge with joysticks, orientation remap, timed coin pulses.
// Optional feature macro: ARCADE_INPUT_AUTOFIRE_EN (adds autofire port and
// per-player autofire counters on p_fire).
// Ports:
//   clk_sys, reset_n            clock, async active-low reset
//   ps2_key[10:0]               [10] toggle, [9] pressed, [8] ext, [7:0] code
//   joystick_0/1[15:0]          hps_io joystick words
//   rotate                      1 = horizontal remap
//   autofire[1:0]               per-player autofire enable (macro only)
//   p_up/down/left/right/fire/bomb[1:0]   player outputs, index = player
//   start[1:0], coin[1:0]       start buttons, coin pulses
//   coin_state_dbg[3:0]         {slot2, slot1} coin FSM state
// All outputs are registered: one cycle from input change to output.
// ---------------------------------------------------------------------------
module arcade_input_ctrl
   import arcade_input_pkg::*;
#(
   parameter int          PLAYERS       = 2,
   parameter logic [15:0] COIN_PULSE    = 16'd32768,
   parameter bit          COIN_ON_START = 1'b1,
   parameter logic [19:0] AF_DIV        = 20'd300000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [10:0] ps2_key,
   input  logic [15:0] joystick_0,
   input  logic [15:0] joystick_1,
   input  logic        rotate,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
   input  logic [1:0]  autofire,
`endif
   output logic [1:0]  p_up,
   output logic [1:0]  p_down,
   output logic [1:0]  p_left,
   output logic [1:0]  p_right,
   output logic [1:0]  p_fire,
   output logic [1:0]  p_bomb,
   output logic [1:0]  start,
   output logic [1:0]  coin,
   output logic [3:0]  coin_state_dbg
);

   localparam int CNT_W = cnt_width(int'(COIN_PULSE), int'(AF_DIV));

   logic       tog_q, primed_q, ev;
   logic [7:0] k1_q, k2_q, k1_next, k2_next;
   logic [5:0] m1, m2, r1, r2;
   logic       st1, st2, req1, req2;
   logic [1:0] fire_held, fire_q;
   coin_state_t cs1, cs2;

   wire unused_joy = &{1'b0, joystick_0[15:9], joystick_1[15:9]};

   // primed_q stays low for the first cycle after reset so the toggle copy
   // picks up the current ps2_key[10] without it counting as an event.
   assign ev = primed_q && (ps2_key[10] != tog_q);

   always_comb begin
      k1_next = k1_q;
      k2_next = k2_q;
      if (ev) begin
         case (ps2_key[7:0])
            SC_UP:    k1_next[JOY_UP]    = ps2_key[9];
            SC_DOWN:  k1_next[JOY_DOWN]  = ps2_key[9];
            SC_LEFT:  k1_next[JOY_LEFT]  = ps2_key[9];
            SC_RIGHT: k1_next[JOY_RIGHT] = ps2_key[9];
            SC_BOMB1: k1_next[JOY_BOMB]  = ps2_key[9];
            default: ;
         endcase
         case (ps2_key[8:0])
            SC_FIRE1:  k1_next[JOY_FIRE]  = ps2_key[9];
            SC_START1: k1_next[KEY_START] = ps2_key[9];
            SC_COIN1:  k1_next[KEY_COIN]  = ps2_key[9];
            SC_UP2:    k2_next[JOY_UP]    = ps2_key[9];
            SC_DOWN2:  k2_next[JOY_DOWN]  = ps2_key[9];
            SC_LEFT2:  k2_next[JOY_LEFT]  = ps2_key[9];
            SC_RIGHT2: k2_next[JOY_RIGHT] = ps2_key[9];
            SC_FIRE2:  k2_next[JOY_FIRE]  = ps2_key[9];
            SC_BOMB2:  k2_next[JOY_BOMB]  = ps2_key[9];
            SC_START2: k2_next[KEY_START] = ps2_key[9];
            SC_COIN2:  k2_next[KEY_COIN]  = ps2_key[9];
            default: ;
         endcase
      end
   end

   // Merge and remap work on the next held-key state so a key event reaches
   // the registered outputs in the same cycle as a joystick change.
   always_comb begin
      m1  = k1_next[5:0] | joystick_0[5:0];
      m2  = k2_next[5:0] | joystick_1[5:0];
      r1  = remap(m1, rotate);
      r2  = (PLAYERS >= 2) ? remap(m2, rotate) : 6'd0;
      st1 = k1_next[KEY_START] | joystick_0[JOY_START1] | joystick_1[JOY_START1];
      st2 = k2_next[KEY_START] | joystick_0[JOY_START2] | joystick_1[JOY_START2];
      req1 = k1_next[KEY_COIN] | joystick_0[JOY_COIN] | (COIN_ON_START & st1);
      req2 = k2_next[KEY_COIN] | joystick_1[JOY_COIN] | (COIN_ON_START & st2);
      fire_held = {r2[JOY_FIRE], r1[JOY_FIRE]};
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         tog_q    <= 1'b0;
         primed_q <= 1'b0;
         k1_q     <= '0;
         k2_q     <= '0;
         p_up     <= '0;
         p_down   <= '0;
         p_left   <= '0;
         p_right  <= '0;
         p_bomb   <= '0;
         start    <= '0;
      end else begin
         tog_q    <= ps2_key[10];
         primed_q <= 1'b1;
         k1_q     <= k1_next;
         k2_q     <= k2_next;
         p_up     <= {r2[JOY_UP],    r1[JOY_UP]};
         p_down   <= {r2[JOY_DOWN],  r1[JOY_DOWN]};
         p_left   <= {r2[JOY_LEFT],  r1[JOY_LEFT]};
         p_right  <= {r2[JOY_RIGHT], r1[JOY_RIGHT]};
         p_bomb   <= {r2[JOY_BOMB],  r1[JOY_BOMB]};
         start    <= {st2, st1};
      end
   end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
   localparam logic [CNT_W-1:0] AF_LOAD = CNT_W'(AF_DIV - 20'd1);
   localparam logic [CNT_W-1:0] AF_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] af_cnt_q [2];
   logic [1:0]       af_run_q;

   // af_run_q marks "already in an autofire burst"; its first cycle drives
   // fire high, then fire flips every AF_DIV cycles.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         af_run_q <= '0;
         fire_q   <= '0;
         for (int i = 0; i < 2; i++) af_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!fire_held[i] || !autofire[i]) begin
               af_run_q[i] <= 1'b0;
               fire_q[i]   <= fire_held[i];
               af_cnt_q[i] <= AF_LOAD;
            end else if (!af_run_q[i]) begin
               af_run_q[i] <= 1'b1;
               fire_q[i]   <= 1'b1;
               af_cnt_q[i] <= AF_LOAD;
            end else if (af_cnt_q[i] == '0) begin
               fire_q[i]   <= ~fire_q[i];
               af_cnt_q[i] <= AF_LOAD;
            end else begin
               af_cnt_q[i] <= af_cnt_q[i] - AF_ONE;
            end
         end
      end
   end
`else
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) fire_q <= '0;
      else          fire_q <= fire_held;
   end
`endif

   assign p_fire = fire_q;

   coin_pulse_gen #(.COIN_PULSE(COIN_PULSE), .CNT_W(CNT_W)) u_coin1 (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .req     (req1),
      .coin    (coin[0]),
      .state   (cs1)
   );

   coin_pulse_gen #(.COIN_PULSE(COIN_PULSE), .CNT_W(CNT_W)) u_coin2 (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .req     (req2),
      .coin    (coin[1]),
      .state   (cs2)
   );

   assign coin_state_dbg = {cs2, cs1};

endmodule

// File: doc/arcade_input_ctrl.md
# arcade_input_ctrl

Player-input front end for arcade cores. It sits between `hps_io` (`ps2_key`, `joystick_0/1`) and the game core. It decodes PS/2 key events into held-key state for up to two players and merges them with joystick bits. It applies the vertical/horizontal orientation remap and generates timed coin pulses, so the core no longer derives coin combinationally from the start buttons.

## Interface
- `PLAYERS`, 2: number of player banks decoded (1 or 2); bank 2 outputs tie to 0 when 1.
- `COIN_PULSE`, 16'd32768: coin output high time, and also lockout gap, in `clk_sys` cycles (≥1).
- `COIN_ON_START`, 1: 1 = a start press also requests a coin for that player; 0 = only coin key/button.
- `AF_DIV`, 20'd300000: autofire half-period in cycles (≥1); used only with `AUTOFIRE_EN`.

Ports:
- `clk_sys` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ps2_key` in 11: [10] event toggle, [9] pressed, [8] extended, [7:0] scancode.
- `joystick_0`, `joystick_1` in 16 each: bit 0 right, 1 left, 2 down, 3 up, 4 fire, 5 bomb, 6 start1, 7 start2, 8 coin.
- `rotate` in 1: 1 = horizontal orientation remap active.
- `autofire` in 2: per-player autofire enable; present only with `AUTOFIRE_EN`.
- `p_up`, `p_down`, `p_left`, `p_right`, `p_fire`, `p_bomb` out 2 each: index = player.
- `start` out 2: start1, start2.
- `coin` out 2: coin pulses, slot 1/2.

## Operation
- Key decode: a registered copy of `ps2_key[10]` detects events. On inequality, the matching held-key register loads `ps2_key[9]`. Extended bit is don't-care except where listed.
- P1 keys: arrows 75/72/6B/74 (any ext), space 029 fire, ctrl X14 bomb, F1 005 start1, 5 (02E) coin1.
- P2 keys: R 02D up, F 02B down, D 023 left, G 034 right, A 01C fire, S 01B bomb, F2 006 start2, 6 (036) coin2.
- Merge: player n = keys_n | joystick_(n-1). Start1/start2 = F1/F2 | joy0[6]/[7] | joy1[6]/[7].
- Rotate remap per player, when `rotate`=1: up←left, down←right, left←down, right←up. Applied after the merge.
- Coin generator per slot, FSM IDLE→PULSE→GAP→IDLE.
  - A rising edge of the request starts PULSE; `coin`=1 for exactly `COIN_PULSE` cycles.
  - GAP holds `coin`=0 for `COIN_PULSE` cycles.
  - Requests in PULSE/GAP are ignored, including their edges. A request still held at GAP end does not retrigger.
  - Request = coin key | joy[8] | (`COIN_ON_START` & start_n).
- Counter width = $clog2(max(COIN_PULSE, AF_DIV)+1), unsigned, saturation-free (reloaded at each state entry).

## Timing
- Reset: all held-key regs, outputs, counters = 0; FSMs = IDLE.
- Prime rule: on the first cycle after `reset_n` deassertion, the toggle copy loads `ps2_key[10]` without decoding, so no spurious event.
- Latency: all outputs registered; one cycle from `ps2_key`/joystick/`rotate` change to output.
- Coin: request edge at cycle t gives `coin` high from t+1 to t+`COIN_PULSE`.
- Reset mid-pulse: `coin` drops asynchronously and the FSM returns to IDLE.

## Configuration
- `ARCADE_INPUT_AUTOFIRE_EN` defined:
  - `autofire` port exists.
  - While fire is held and `autofire[n]`=1, `p_fire[n]` toggles every `AF_DIV` cycles, starting high on the first held cycle.
  - Release forces 0 and reloads the counter.
- Undefined: no port, no counter; `p_fire` = held fire.

## Structure
- `arcade_input_pkg`:
  - scancode localparams;
  - joystick bit indices;
  - `coin_state_t` enum {IDLE, PULSE, GAP}.
- Sub-module `coin_pulse_gen` (params `COIN_PULSE`), instantiated once per coin slot.

## Test plan
- Key press/release: toggle event 0x075 pressed → `p_up[0]`=1 after 1 cycle; release event → 0. Same event with `rotate`=1 → `p_right[0]`=1.
- Prime rule: hold `ps2_key[10]`=1 through reset release → no output change for 100 cycles.
- Coin pulse: `joystick_0[8]` rises with `COIN_PULSE`=4 → `coin[0]` high exactly 4 cycles. A second edge 2 cycles into GAP → ignored. An edge after GAP → new pulse.
- `COIN_ON_START`: F2 press → `start[1]`=1 and `coin[1]` pulse. With param 0 → no coin.
- Merge/PLAYERS=1: key D plus `joystick_1[1]` → `p_left[1]`=1 with PLAYERS=2. PLAYERS=1 → `p_left[1]`=0.
- Autofire (macro on, `AF_DIV`=3): hold space with `autofire[0]`=1 → `p_fire[0]` pattern 1,1,1,0,0,0,…. Release → 0 next cycle. Reset mid-pulse → `coin`=0 immediately.
